bus_timer6502: RTL

//  Memory-mapped 16-bit down-counter timer on the cpu6502 bus. The CPU is the initiator; this

---
 rtl/bus_timer6502.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bus_timer6502.sv
// Memory-mapped 16-bit down-counter timer for the cpu6502 bus.
// Decodes an 8-byte window, uses phi2 edges for bus timing and drives an active-low irq.
module bus_timer6502 #(
  parameter logic [15:0] BASE    = 16'hD000,
  parameter logic [15:0] RST_LAT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rw,
  input  logic        clk2,
  output logic [7:0]  rdata,
  output logic        oe,
  output logic        irq_n
);

  localparam logic [2:0] A_CNT_LO = 3'd0;
  localparam logic [2:0] A_CNT_HI = 3'd1;
  localparam logic [2:0] A_LAT_LO = 3'd2;
  localparam logic [2:0] A_LAT_HI = 3'd3;
  localparam logic [2:0] A_CTRL   = 3'd4;
  localparam logic [2:0] A_STAT   = 3'd5;
  localparam logic [2:0] A_PRESC  = 3'd6;

  logic [15:0] r_cnt;
  logic [15:0] r_latch;
  logic        r_en;
  logic        r_reload;
  logic        r_ie;
  logic        r_if;
  logic [7:0]  r_prescale;
  logic [7:0]  r_pcnt;
  logic        r_clk2_q;
  logic        r_irq_n;

  logic        w_sel;
  logic [2:0]  w_reg;
  logic        w_p2_rise;
  logic        w_p2_fall;
  logic        w_wr;
  logic        w_rd_fall;
  logic        w_load;
  logic        w_tick;
  logic        w_underflow;

  assign w_sel       = (addr[15:3] == BASE[15:3]);
  assign w_reg       = addr[2:0];
  assign w_p2_rise   = clk2 & ~r_clk2_q;
  assign w_p2_fall   = ~clk2 & r_clk2_q;
  assign w_wr        = w_p2_rise & w_sel & ~rw;
  assign w_rd_fall   = w_p2_fall & w_sel & rw;
  assign w_load      = w_wr & (w_reg == A_CNT_HI);
  // A CNT_HI load swallows the tick of the same phi2 cycle entirely.
  assign w_tick      = w_p2_rise & r_en & (r_pcnt == r_prescale) & ~w_load;
  assign w_underflow = w_tick & (r_cnt == 16'h0000);

  // NOTE: async reset in the sensitivity list; all state uses non-blocking assignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk2_q <= 1'b0;
      r_irq_n  <= 1'b1;
    end else begin
      r_clk2_q <= clk2;
      r_irq_n  <= ~(r_if & r_ie);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= RST_LAT;
    end else if (w_load) begin
      r_cnt <= {wdata, r_latch[7:0]};
    end else if (w_tick) begin
      if (r_cnt != 16'h0000) r_cnt <= r_cnt - 16'd1;
      else if (r_reload)     r_cnt <= r_latch;
      else                   r_cnt <= 16'hFFFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_latch    <= RST_LAT;
      r_prescale <= 8'h00;
    end else if (w_wr) begin
      if (w_reg == A_CNT_LO || w_reg == A_LAT_LO) r_latch[7:0]  <= wdata;
      if (w_reg == A_CNT_HI || w_reg == A_LAT_HI) r_latch[15:8] <= wdata;
      if (w_reg == A_PRESC)                       r_prescale    <= wdata;
    end
  end

  // The CPU's CTRL write takes precedence over the one-shot auto-disable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en     <= 1'b0;
      r_reload <= 1'b0;
      r_ie     <= 1'b0;
    end else if (w_wr && w_reg == A_CTRL) begin
      r_en     <= wdata[0];
      r_reload <= wdata[1];
      r_ie     <= wdata[2];
    end else if (w_underflow && !r_reload) begin
      r_en     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if <= 1'b0;
    end else if (w_underflow) begin
      r_if <= 1'b1;
    end else if (w_load || (w_wr && w_reg == A_STAT && wdata[7]) ||
                 (w_rd_fall && w_reg == A_STAT)) begin
      r_if <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= 8'h00;
    end else if (w_load) begin
      r_pcnt <= 8'h00;
    end else if (w_p2_rise && r_en) begin
      r_pcnt <= (r_pcnt == r_prescale) ? 8'h00 : r_pcnt + 8'd1;
    end
  end

  assign oe    = w_sel & rw;
  assign irq_n = r_irq_n;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rdata = 8'h00;
    if (oe) begin
      case (w_reg)
        A_CNT_LO: rdata = r_cnt[7:0];
        A_CNT_HI: rdata = r_cnt[15:8];
        A_LAT_LO: rdata = r_latch[7:0];
        A_LAT_HI: rdata = r_latch[15:8];
        A_CTRL:   rdata = {5'b00000, r_ie, r_reload, r_en};
        A_STAT:   rdata = {r_if, 7'b0000000};
        A_PRESC:  rdata = r_prescale;
        default:  rdata = 8'h00;
      endcase
    end
  end

endmodule
